ifft_bitrev_reorder: RTL

Output reorder buffer at the far end of the 128-point SDF IFFT chain. It consumes the serial, bit-reversed-order sample stream and its valid strobe, stores each frame in one half of a ping-pong RAM, and replays it in natural order to the correlation peak-search logic. It also flags frames whose end marker does not line up with the last sample.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/sdf_reorder_ram.sv | 38 +++
 rtl/ifft_bitrev_reorder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the SDF IFFT datapath: sample width derivation,
// complex sample type, read-FSM state type and index bit reversal.
package fft_pkg;

   localparam int DEFAULT_INTEGER_SIZE = 8;
   localparam int DEFAULT_FRACT_SIZE   = 8;
   localparam int MAX_LOG2N            = 16;

   function automatic int calc_data_width(input int integer_size, input int fract_size);
      return integer_size + fract_size;
   endfunction

   localparam int DEFAULT_DATA_WIDTH = calc_data_width(DEFAULT_INTEGER_SIZE, DEFAULT_FRACT_SIZE);

   typedef struct packed {
      logic signed [DEFAULT_DATA_WIDTH-1:0] re;
      logic signed [DEFAULT_DATA_WIDTH-1:0] im;
   } cplx_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rd_state_e;

   // Reverses the low nbits of idx; bits at and above nbits return as zero.
   function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                   input int nbits);
      logic [MAX_LOG2N-1:0] rev;
      rev = {MAX_LOG2N{1'b0}};
      for (int b = 0; b < MAX_LOG2N; b++) begin
         if (b < nbits) begin
            rev[b] = idx[4'(nbits - 1 - b)];
         end else begin
            rev[b] = 1'b0;
         end
      end
      return rev;
   endfunction

endpackage

// File: rtl/sdf_reorder_ram.sv
// Simple dual-port frame RAM: one write port, one read port with a
// registered output that clears on reset (the array itself is never cleared).
module sdf_reorder_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WORD_WIDTH-1:0] rd_data
);

   logic [WORD_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
   logic [WORD_WIDTH-1:0] rd_data_r;

   // Storage array write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read; holds its value between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= {WORD_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/ifft_bitrev_reorder.sv
// Ping-pong reorder buffer: stores bit-reversed IFFT frames and replays them
// in natural order, flagging frames whose end marker arrives early.
module ifft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter  int INTEGER_SIZE = DEFAULT_INTEGER_SIZE,
   parameter  int FRACT_SIZE   = DEFAULT_FRACT_SIZE,
   parameter  int NFFT         = 128,
   localparam int DATA_WIDTH   = calc_data_width(INTEGER_SIZE, FRACT_SIZE),
   localparam int LOG2N        = $clog2(NFFT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic signed [DATA_WIDTH-1:0] in_r,
   input  logic signed [DATA_WIDTH-1:0] in_i,
   output logic                         out_valid,
   output logic                         out_first,
   output logic                         out_last,
   output logic        [LOG2N-1:0]      out_index,
   output logic signed [DATA_WIDTH-1:0] out_r,
   output logic signed [DATA_WIDTH-1:0] out_i,
   output logic                         frame_err
);

   localparam logic [LOG2N-1:0] ZERO_IDX = {LOG2N{1'b0}};
   localparam logic [LOG2N-1:0] ONE_IDX  = LOG2N'(1);
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NFFT - 1);

   logic [LOG2N-1:0]        wcnt_r;
   logic                    wbank_r;
   logic                    frame_err_r;
   logic [1:0]              full_r;
   logic [1:0]              full_next_s;
   logic [1:0]              full_set_s;
   logic [1:0]              full_clr_s;
   rd_state_e               state_r;
   rd_state_e               state_next_s;
   logic [LOG2N-1:0]        rcnt_r;
   logic [LOG2N-1:0]        rcnt_next_s;
   logic                    rbank_r;
   logic                    rbank_next_s;
   logic                    rd_en_s;
   logic                    rd_done_s;
   logic                    wr_at_last_s;
   logic                    wr_abort_s;
   logic                    wr_en_s;
   logic                    wr_done_s;
   logic [LOG2N-1:0]        wr_rev_s;
   logic [LOG2N:0]          wr_addr_s;
   logic [LOG2N:0]          rd_addr_s;
   logic [2*DATA_WIDTH-1:0] rd_data_s;
   logic                    out_valid_r;
   logic                    out_first_r;
   logic                    out_last_r;
   logic [LOG2N-1:0]        out_index_r;

   // An early end marker drops the sample and the partial frame in the same bank.
   assign wr_at_last_s = (wcnt_r == LAST_IDX);
   assign wr_abort_s   = in_valid & in_last & ~wr_at_last_s;
   assign wr_en_s      = in_valid & ~wr_abort_s;
   assign wr_done_s    = wr_en_s & wr_at_last_s;
   assign wr_rev_s     = LOG2N'(bitrev(MAX_LOG2N'(wcnt_r), LOG2N));
   assign wr_addr_s    = {wbank_r, wr_rev_s};
   assign rd_addr_s    = {rbank_r, rcnt_r};

   // Write counter, write bank and sticky misalignment flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_r      <= ZERO_IDX;
         wbank_r     <= 1'b0;
         frame_err_r <= 1'b0;
      end else if (wr_abort_s) begin
         wcnt_r      <= ZERO_IDX;
         frame_err_r <= 1'b1;
      end else if (wr_done_s) begin
         wcnt_r  <= ZERO_IDX;
         wbank_r <= ~wbank_r;
      end else if (wr_en_s) begin
         wcnt_r <= wcnt_r + ONE_IDX;
      end
   end

   assign full_set_s  = wr_done_s ? (2'b01 << wbank_r) : 2'b00;
   assign full_clr_s  = rd_done_s ? (2'b01 << rbank_r) : 2'b00;
   assign full_next_s = (full_r & ~full_clr_s) | full_set_s;

   // Read FSM next state: chains straight into the other bank when it is ready
   always_comb begin
      state_next_s = state_r;
      rcnt_next_s  = rcnt_r;
      rbank_next_s = rbank_r;
      rd_en_s      = 1'b0;
      rd_done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            rcnt_next_s = ZERO_IDX;
            if (full_r[rbank_r]) begin
               state_next_s = ST_READ;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_READ: begin
            rd_en_s = 1'b1;
            if (rcnt_r == LAST_IDX) begin
               rd_done_s    = 1'b1;
               rbank_next_s = ~rbank_r;
               rcnt_next_s  = ZERO_IDX;
               if (full_r[~rbank_r] | (wr_done_s & (wbank_r != rbank_r))) begin
                  state_next_s = ST_READ;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               rcnt_next_s = rcnt_r + ONE_IDX;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            rcnt_next_s  = ZERO_IDX;
         end
      endcase
   end

   // Read FSM state, read pointer and bank-full flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rcnt_r  <= ZERO_IDX;
         rbank_r <= 1'b0;
         full_r  <= 2'b00;
      end else begin
         state_r <= state_next_s;
         rcnt_r  <= rcnt_next_s;
         rbank_r <= rbank_next_s;
         full_r  <= full_next_s;
      end
   end

   // Sideband pipeline, one stage to line up with the registered RAM read
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_first_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_index_r <= ZERO_IDX;
      end else begin
         out_valid_r <= rd_en_s;
         out_first_r <= rd_en_s & (rcnt_r == ZERO_IDX);
         out_last_r  <= rd_en_s & (rcnt_r == LAST_IDX);
         if (rd_en_s) begin
            out_index_r <= rcnt_r;
         end
      end
   end

   sdf_reorder_ram #(
      .ADDR_WIDTH(LOG2N + 1),
      .WORD_WIDTH(2 * DATA_WIDTH)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en_s),
      .wr_addr(wr_addr_s),
      .wr_data({in_r, in_i}),
      .rd_en  (rd_en_s),
      .rd_addr(rd_addr_s),
      .rd_data(rd_data_s)
   );

   assign out_valid = out_valid_r;
   assign out_first = out_first_r;
   assign out_last  = out_last_r;
   assign out_index = out_index_r;
   assign out_r     = rd_data_s[2*DATA_WIDTH-1:DATA_WIDTH];
   assign out_i     = rd_data_s[DATA_WIDTH-1:0];
   assign frame_err = frame_err_r;

endmodule
